// File: rtl/uart_frame_rx.sv
// Frame parser on the UART RX FIFO: hunts for SYNC, reads LEN, payload and CHK,
// then releases the buffered payload on a valid/ready stream if the XOR checksum matches.
module uart_frame_rx #(
   parameter int unsigned      DBITS       = 16,
   parameter int unsigned      MAX_LEN     = 32,
   parameter int unsigned      LEN_BITS    = 6,
   parameter logic [DBITS-1:0] SYNC_WORD   = 16'hA55A,
   parameter int unsigned      TIMEOUT_CYC = 100000,
   parameter int unsigned      TO_BITS     = 17
) (
   input  logic             clk_100MHz,
   input  logic             reset_n,
   input  logic             rx_empty,
   input  logic [DBITS-1:0] read_data,
   output logic             read_uart,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DBITS-1:0] out_data,
   output logic             out_last,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic [15:0]      frame_count,
   output logic             busy
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_BITS-1:0] LenOne = LEN_BITS'(1);
   localparam logic [TO_BITS-1:0]  ToOne  = TO_BITS'(1);
   localparam logic [TO_BITS-1:0]  ToLast = TO_BITS'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {StHunt, StLen, StPay, StChk, StOut} state_e;

   state_e              state_q, state_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [LEN_BITS-1:0] idx_q, idx_d;
   logic [LEN_BITS-1:0] rptr_q, rptr_d;
   logic [DBITS-1:0]    chk_q, chk_d;
   logic [TO_BITS-1:0]  to_q, to_d;
   logic [1:0]          code_q, code_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                ok_q, ok_d;
   logic                err_q, err_d;
   logic                wr_en;
   logic                len_ok;
   logic                rd_last;

   logic [DBITS-1:0] pay_mem [MAX_LEN];

   // Gated by reset so every output reads zero while reset is held.
   assign read_uart   = reset_n & ~rx_empty & (state_q != StOut);
   assign out_valid   = (state_q == StOut);
   assign rd_last     = (rptr_q == len_q - LenOne);
   assign out_last    = out_valid & rd_last;
   assign out_data    = out_valid ? pay_mem[rptr_q[AW-1:0]] : '0;
   assign frame_ok    = ok_q;
   assign frame_err   = err_q;
   assign err_code    = code_q;
   assign frame_count = cnt_q;
   assign busy        = (state_q != StHunt);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rptr_d  = rptr_q;
      chk_d   = chk_q;
      to_d    = to_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      len_ok  = (read_data != '0) && (read_data <= DBITS'(MAX_LEN));

      // Inactivity watchdog; any pop below overrides it since a pop implies FIFO non-empty.
      if (state_q == StLen || state_q == StPay || state_q == StChk) begin
         if (read_uart) begin
            to_d = '0;
         end else if (to_q == ToLast) begin
            state_d = StHunt;
            err_d   = 1'b1;
            code_d  = 2'd3;
            to_d    = '0;
         end else begin
            to_d = to_q + ToOne;
         end
      end

      unique case (state_q)
         StHunt: begin
            if (read_uart && read_data == SYNC_WORD) begin
               state_d = StLen;
               to_d    = '0;
            end
         end
         StLen: begin
            if (read_uart) begin
               if (len_ok) begin
                  len_d   = read_data[LEN_BITS-1:0];
                  chk_d   = read_data;
                  idx_d   = '0;
                  state_d = StPay;
               end else begin
                  state_d = StHunt;
                  err_d   = 1'b1;
                  code_d  = 2'd1;
               end
            end
         end
         StPay: begin
            if (read_uart) begin
               wr_en = 1'b1;
               chk_d = chk_q ^ read_data;
               idx_d = idx_q + LenOne;
               if (idx_q == len_q - LenOne) state_d = StChk;
            end
         end
         StChk: begin
            if (read_uart) begin
               if (read_data == chk_q) begin
                  state_d = StOut;
                  ok_d    = 1'b1;
                  rptr_d  = '0;
                  if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
               end else begin
                  state_d = StHunt;
                  err_d   = 1'b1;
                  code_d  = 2'd2;
               end
            end
         end
         StOut: begin
            if (out_ready) begin
               rptr_d = rptr_q + LenOne;
               if (rd_last) state_d = StHunt;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StHunt;
         len_q   <= '0;
         idx_q   <= '0;
         rptr_q  <= '0;
         chk_q   <= '0;
         to_q    <= '0;
         code_q  <= '0;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rptr_q  <= rptr_d;
         chk_q   <= chk_d;
         to_q    <= to_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (wr_en) pay_mem[idx_q[AW-1:0]] <= read_data;
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a queue-modelled FIFO feeds directed frames and a
// negedge monitor compares output words and frame events against expectation queues.
module tb_uart_frame_rx;

   localparam int unsigned TO = 100;

   typedef struct packed {logic [15:0] data; logic last;} out_t;
   typedef struct packed {logic ok; logic [1:0] code;} evt_t;

   logic        clk_100MHz = 1'b0;
   logic        reset_n    = 1'b0;
   logic        rx_empty   = 1'b1;
   logic [15:0] read_data  = 16'h0;
   logic        out_ready  = 1'b1;
   logic        read_uart, out_valid, out_last, frame_ok, frame_err, busy;
   logic [15:0] out_data, frame_count;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_pop_cyc = 0;
   int err_cyc = 0;
   bit popped_now;

   logic [15:0] fifo[$];
   out_t        exp_out[$];
   evt_t        exp_evt[$];
   int          xfer_cyc[$];

   always #5 clk_100MHz = ~clk_100MHz;

   uart_frame_rx #(
      .DBITS(16), .MAX_LEN(32), .LEN_BITS(6), .SYNC_WORD(16'hA55A),
      .TIMEOUT_CYC(TO), .TO_BITS(17)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .rx_empty   (rx_empty),
      .read_data  (read_data),
      .read_uart  (read_uart),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .frame_count(frame_count),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   function automatic void drive_fifo();
      rx_empty = (fifo.size() == 0);
      if (fifo.size() != 0) read_data = fifo[0];
      else read_data = 16'h0;
   endfunction

   // FIFO model: the head is consumed just after each edge where read_uart was high.
   always @(posedge clk_100MHz) begin
      cyc++;
      popped_now = read_uart;
      #1;
      if (popped_now) begin
         if (fifo.size() > 0) void'(fifo.pop_front());
         last_pop_cyc = cyc;
         drive_fifo();
      end
   end

   always @(negedge clk_100MHz) begin
      if (reset_n) begin
         if (out_valid && out_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_out.size() == 0) begin
               fail("unexpected_out", $sformatf("got word 0x%0h, expected none", out_data));
            end else begin
               out_t e;
               e = exp_out.pop_front();
               check("out_data", out_data, e.data);
               check("out_last", out_last, e.last);
            end
         end
         if (frame_ok || frame_err) begin
            check("ok_err_exclusive", frame_ok & frame_err, 0);
            if (frame_err) err_cyc = cyc;
            if (exp_evt.size() == 0) begin
               fail("unexpected_event", $sformatf("got ok=%0b err=%0b, expected none",
                                                   frame_ok, frame_err));
            end else begin
               evt_t ev;
               ev = exp_evt.pop_front();
               check("frame_ok", frame_ok, ev.ok);
               check("frame_err", frame_err, !ev.ok);
               if (!ev.ok) check("err_code", err_code, ev.code);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100MHz);
      #2;
   endtask

   task automatic push(input logic [15:0] w);
      fifo.push_back(w);
      drive_fifo();
   endtask

   task automatic exp_w(input logic [15:0] d, input logic l);
      out_t e;
      e.data = d;
      e.last = l;
      exp_out.push_back(e);
   endtask

   task automatic exp_e(input logic ok, input logic [1:0] code);
      evt_t e;
      e.ok   = ok;
      e.code = code;
      exp_evt.push_back(e);
   endtask

   function automatic bit idle();
      return fifo.size() == 0 && !busy && exp_out.size() == 0 && exp_evt.size() == 0;
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!idle() && n < budget) begin
         tick(1);
         n++;
      end
      if (!idle()) fail(name, "still busy or expectations pending, expected idle");
   endtask

   task automatic frame1(input logic [15:0] chk);
      push(16'hA55A); push(16'h0003); push(16'h1111);
      push(16'h2222); push(16'h4444); push(chk);
   endtask

   initial begin
      tick(3);
      check("reset_ctl", {read_uart, out_valid, out_last, frame_ok, frame_err, err_code, busy}, 0);
      check("reset_data", out_data, 0);
      check("reset_count", frame_count, 0);
      reset_n = 1'b1;
      tick(2);

      // Scenario 1: basic good frame
      frame1(16'h7774);
      exp_w(16'h1111, 1'b0); exp_w(16'h2222, 1'b0); exp_w(16'h4444, 1'b1);
      exp_e(1'b1, 2'd0);
      wait_idle("s1_idle", 100);
      if (xfer_cyc.size() == 3) check("s1_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);
      else fail("s1_xfers", $sformatf("got %0d transfers, expected 3", xfer_cyc.size()));
      check("s1_count", frame_count, 1);
      check("s1_busy", busy, 0);

      // Scenario 2: bad checksum, then good frame; err_code held
      frame1(16'h7775);
      exp_e(1'b0, 2'd2);
      wait_idle("s2_bad_idle", 100);
      check("s2_count_bad", frame_count, 1);
      frame1(16'h7774);
      exp_w(16'h1111, 1'b0); exp_w(16'h2222, 1'b0); exp_w(16'h4444, 1'b1);
      exp_e(1'b1, 2'd0);
      wait_idle("s2_good_idle", 100);
      check("s2_count_good", frame_count, 2);
      check("s2_code_held", err_code, 2);

      // Scenario 3: leading garbage
      push(16'h0000); push(16'h1234); push(16'hA5A5);
      frame1(16'h7774);
      exp_w(16'h1111, 1'b0); exp_w(16'h2222, 1'b0); exp_w(16'h4444, 1'b1);
      exp_e(1'b1, 2'd0);
      wait_idle("s3_idle", 100);
      check("s3_count", frame_count, 3);

      // Scenario 4: bad lengths (0, 33, high bits set), then a good 1-word frame and a full one
      push(16'hA55A); push(16'h0000); exp_e(1'b0, 2'd1);
      wait_idle("s4_len0", 300);
      push(16'hA55A); push(16'h0021); exp_e(1'b0, 2'd1);
      wait_idle("s4_len33", 300);
      push(16'hA55A); push(16'h8003); exp_e(1'b0, 2'd1);
      wait_idle("s4_len_hi", 300);
      check("s4_busy", busy, 0);
      push(16'hA55A); push(16'h0001); push(16'hBEEF); push(16'hBEEE);
      exp_w(16'hBEEF, 1'b1); exp_e(1'b1, 2'd0);
      wait_idle("s4_len1", 100);
      check("s4_count1", frame_count, 4);
      begin
         logic [15:0] c;
         c = 16'h0020;
         push(16'hA55A); push(16'h0020);
         for (int i = 0; i < 32; i++) begin
            push(16'h0100 + 16'(i));
            c = c ^ (16'h0100 + 16'(i));
            exp_w(16'h0100 + 16'(i), i == 31);
         end
         push(c);
         exp_e(1'b1, 2'd0);
      end
      wait_idle("s4_len32", 200);
      check("s4_count32", frame_count, 5);

      // Scenario 5: timeout mid-payload
      push(16'hA55A); push(16'h0002); push(16'hAAAA);
      exp_e(1'b0, 2'd3);
      wait_idle("s5_idle", 300);
      check("s5_latency", err_cyc - last_pop_cyc, TO);
      check("s5_busy", busy, 0);
      check("s5_count", frame_count, 5);

      // Scenario 6: backpressure with words queued behind, then reset mid-payload
      push(16'hA55A); push(16'h0003); push(16'h0A0A); push(16'h0B0B);
      push(16'h0C0C); push(16'h0D0E);
      push(16'hA55A); push(16'h0002); push(16'h5555);
      exp_w(16'h0A0A, 1'b0); exp_w(16'h0B0B, 1'b0); exp_w(16'h0C0C, 1'b1);
      exp_e(1'b1, 2'd0);
      begin
         int n = 0;
         logic [3:0] pat;
         pat = 4'b1001;
         while (!out_valid && n < 50) begin
            tick(1);
            n++;
         end
         if (!out_valid) fail("s6_out_valid", "got out_valid=0, expected 1");
         for (int k = 0; k < 12; k++) begin
            if (!out_valid) break;
            out_ready = pat[k % 4];
            #1;
            check("s6_no_pop_in_out", {rx_empty, read_uart}, 2'b00);
            tick(1);
         end
         out_ready = 1'b1;
         n = 0;
         while (fifo.size() != 0 && n < 20) begin
            tick(1);
            n++;
         end
      end
      tick(2);
      check("s6_pending", exp_out.size() + exp_evt.size(), 0);
      check("s6_busy_mid_pay", busy, 1);
      check("s6_count", frame_count, 6);
      reset_n = 1'b0;
      #1;
      check("s6_reset_ctl", {read_uart, out_valid, out_last, frame_ok, frame_err, err_code, busy}, 0);
      check("s6_reset_data", out_data, 0);
      check("s6_reset_count", frame_count, 0);
      tick(2);
      reset_n = 1'b1;
      tick(3);
      check("s6_after_reset_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500 us, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
